reg_stack_file: RTL and testbench



---
 rtl/rf_pkg.sv | 19 +
 rtl/lifo_stack.sv | 88 ++++++++
 rtl/reg_stack_file.sv | 83 ++++++++
 tb/tb_reg_stack_file.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: default parameters and stack-operation encoding shared by the register/stack file.
package rf_pkg;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_NREGS       = 8;
    localparam int DEF_STACK_DEPTH = 8;
    localparam int DEF_PC_W        = 8;
    localparam int DEF_ZERO_REG    = 1;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_SWAP = 2'b11
    } stack_op_e;

    function automatic stack_op_e decode_op(input logic push, input logic pop);
        return stack_op_e'({pop, push});
    endfunction
endpackage

// File: rtl/lifo_stack.sv
// lifo_stack: return-address LIFO with one-cycle registered pop, push/pop swap and sticky error.
module lifo_stack
    import rf_pkg::*;
#(
    parameter int DEPTH = DEF_STACK_DEPTH,
    parameter int PC_W  = DEF_PC_W,
    parameter int SW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic [PC_W-1:0] push_pc,
    input  logic            pop,
    input  logic            err_clr,
    output logic            pop_valid,
    output logic [PC_W-1:0] pop_pc,
    output logic            full,
    output logic            empty,
    output logic [SW-1:0]   count,
    output logic            err
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [PC_W-1:0] mem_q [DEPTH];
    logic [PC_W-1:0] mem_d [DEPTH];
    logic [SW-1:0]   count_q, count_d;
    logic [PC_W-1:0] pop_pc_q, pop_pc_d;
    logic            pop_valid_q, pop_valid_d;
    logic            err_q, err_d;
    logic [IW-1:0]   wr_idx, top_idx;

    assign wr_idx    = IW'(count_q);
    assign top_idx   = IW'(count_q - 1'b1);
    assign full      = count_q == SW'(DEPTH);
    assign empty     = count_q == '0;
    assign count     = count_q;
    assign pop_pc    = pop_pc_q;
    assign pop_valid = pop_valid_q;
    assign err       = err_q;

    // Clear is applied first so a same-cycle error overrides it.
    always_comb begin
        mem_d       = mem_q;
        count_d     = count_q;
        pop_pc_d    = pop_pc_q;
        pop_valid_d = 1'b0;
        err_d       = err_q & ~err_clr;
        case (decode_op(push, pop))
            OP_PUSH: begin
                if (full) err_d = 1'b1;
                else begin
                    mem_d[wr_idx] = push_pc;
                    count_d       = count_q + 1'b1;
                end
            end
            OP_POP: begin
                if (empty) err_d = 1'b1;
                else begin
                    pop_pc_d    = mem_q[top_idx];
                    pop_valid_d = 1'b1;
                    count_d     = count_q - 1'b1;
                end
            end
            OP_SWAP: begin
                pop_valid_d = 1'b1;
                pop_pc_d    = empty ? push_pc : mem_q[top_idx];
                if (!empty) mem_d[top_idx] = push_pc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
            count_q     <= '0;
            pop_pc_q    <= '0;
            pop_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            count_q     <= count_d;
            pop_pc_q    <= pop_pc_d;
            pop_valid_q <= pop_valid_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: rtl/reg_stack_file.sv
// reg_stack_file: 2R1W register file with write bypass and optional hardwired zero register,
// alongside an independent return-address stack.
module reg_stack_file
    import rf_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int NREGS       = DEF_NREGS,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH,
    parameter int PC_W        = DEF_PC_W,
    parameter int ZERO_REG    = DEF_ZERO_REG,
    localparam int AW         = NREGS > 1 ? $clog2(NREGS) : 1,
    localparam int SW         = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     ws,
    input  logic [DATA_W-1:0] wd,
    input  logic [AW-1:0]     rs1,
    input  logic [AW-1:0]     rs2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              push,
    input  logic [PC_W-1:0]   push_pc,
    input  logic              pop,
    output logic              pop_valid,
    output logic [PC_W-1:0]   pop_pc,
    output logic              stack_full,
    output logic              stack_empty,
    output logic [SW-1:0]     stack_count,
    output logic              stack_err,
    input  logic              err_clr
);
    logic [DATA_W-1:0] regs_q [NREGS];
    logic              wr_ok;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < (AW + 1)'(NREGS);
    endfunction

    function automatic logic is_zero(input logic [AW-1:0] a);
        return ZERO_REG != 0 && a == '0;
    endfunction

    function automatic logic [DATA_W-1:0] rd_port(input logic [AW-1:0] rs);
        if (is_zero(rs) || !in_range(rs)) return '0;
        return (wr_en && ws == rs) ? wd : regs_q[rs];
    endfunction

    assign wr_ok = wr_en && in_range(ws) && !is_zero(ws);

    always_comb begin
        rd1 = rd_port(rs1);
        rd2 = rd_port(rs2);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NREGS; k++) regs_q[k] <= '0;
        end else if (wr_ok) begin
            regs_q[ws] <= wd;
        end
    end

    lifo_stack #(
        .DEPTH(STACK_DEPTH),
        .PC_W (PC_W),
        .SW   (SW)
    ) u_stack (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_pc  (push_pc),
        .pop      (pop),
        .err_clr  (err_clr),
        .pop_valid(pop_valid),
        .pop_pc   (pop_pc),
        .full     (stack_full),
        .empty    (stack_empty),
        .count    (stack_count),
        .err      (stack_err)
    );
endmodule

// File: tb/tb_reg_stack_file.sv
// tb_reg_stack_file: directed stimulus with a pop scoreboard checked by an independent monitor.
module tb_reg_stack_file;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  ws = '0;
    logic [31:0] wd = '0;
    logic [2:0]  rs1 = 3'd3;
    logic [2:0]  rs2 = 3'd7;
    logic [31:0] rd1, rd2;
    logic        push = 1'b0;
    logic [7:0]  push_pc = '0;
    logic        pop = 1'b0;
    logic        pop_valid;
    logic [7:0]  pop_pc;
    logic        stack_full, stack_empty, stack_err;
    logic [3:0]  stack_count;
    logic        err_clr = 1'b0;

    int          n_pass = 0;
    int          n_tot = 0;
    logic [7:0]  exp_q[$];

    reg_stack_file dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .ws(ws), .wd(wd),
        .rs1(rs1), .rs2(rs2), .rd1(rd1), .rd2(rd2),
        .push(push), .push_pc(push_pc), .pop(pop),
        .pop_valid(pop_valid), .pop_pc(pop_pc),
        .stack_full(stack_full), .stack_empty(stack_empty),
        .stack_count(stack_count), .stack_err(stack_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [7:0] v);
        push = 1'b1; push_pc = v;
        cyc();
        push = 1'b0;
    endtask

    task automatic do_pop(input logic [7:0] v);
        exp_q.push_back(v);
        pop = 1'b1;
        cyc();
        pop = 1'b0;
    endtask

    always @(negedge clk) begin
        if (pop_valid) begin
            if (exp_q.size() == 0) begin
                n_tot++;
                $display("FAIL unexpected_pop: got pop_valid=1 pop_pc=0x%0h expected no pop", pop_pc);
            end else chk("pop_pc", {24'd0, pop_pc}, {24'd0, exp_q.pop_front()});
        end
    end

    initial begin
        #2;
        chk("rst_count", {28'd0, stack_count}, 0);
        chk("rst_empty", {31'd0, stack_empty}, 1);
        chk("rst_full", {31'd0, stack_full}, 0);
        chk("rst_err", {31'd0, stack_err}, 0);
        chk("rst_popv", {31'd0, pop_valid}, 0);
        chk("rst_rd1", rd1, 0);
        #10 reset = 1'b1;

        wr_en = 1'b1; ws = 3'd3; wd = 32'hDEADBEEF; rs1 = 3'd3; rs2 = 3'd3;
        #1;
        chk("bypass_rd1", rd1, 32'hDEADBEEF);
        chk("bypass_rd2", rd2, 32'hDEADBEEF);
        cyc();
        wr_en = 1'b0;
        #1 chk("stored_rd1", rd1, 32'hDEADBEEF);
        wr_en = 1'b1; ws = 3'd7; wd = 32'h1234; rs2 = 3'd7;
        cyc();
        wr_en = 1'b0;
        #1 chk("reg7_rd2", rd2, 32'h1234);
        wr_en = 1'b1; ws = 3'd0; wd = 32'h5; rs1 = 3'd0;
        #1 chk("zero_bypass", rd1, 0);
        cyc();
        wr_en = 1'b0;
        #1 chk("zero_stored", rd1, 0);

        wr_en = 1'b1; ws = 3'd2; wd = 32'h77; rs1 = 3'd2;
        do_push(8'h10);
        wr_en = 1'b0;
        chk("cnt_1", {28'd0, stack_count}, 1);
        chk("concurrent_reg", rd1, 32'h77);
        do_push(8'h20);
        chk("cnt_2", {28'd0, stack_count}, 2);
        do_pop(8'h20);
        chk("popv_hi", {31'd0, pop_valid}, 1);
        chk("cnt_after_pop1", {28'd0, stack_count}, 1);
        do_pop(8'h10);
        chk("cnt_after_pop2", {28'd0, stack_count}, 0);
        chk("empty_after", {31'd0, stack_empty}, 1);
        cyc();
        chk("popv_lo", {31'd0, pop_valid}, 0);

        for (int i = 1; i <= 8; i++) do_push(8'(i));
        chk("full_8", {31'd0, stack_full}, 1);
        chk("no_err_8", {31'd0, stack_err}, 0);
        do_push(8'h09);
        chk("cnt_9", {28'd0, stack_count}, 8);
        chk("err_ovf", {31'd0, stack_err}, 1);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        chk("err_clr", {31'd0, stack_err}, 0);
        for (int i = 8; i >= 1; i--) do_pop(8'(i));
        chk("empty_drain", {31'd0, stack_empty}, 1);
        pop = 1'b1; err_clr = 1'b1;
        cyc();
        pop = 1'b0; err_clr = 1'b0;
        chk("udf_popv", {31'd0, pop_valid}, 0);
        chk("udf_pc_held", {24'd0, pop_pc}, 8'h01);
        chk("udf_err_wins", {31'd0, stack_err}, 1);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        chk("err_clr2", {31'd0, stack_err}, 0);

        do_push(8'h33);
        push = 1'b1; push_pc = 8'h44; exp_q.push_back(8'h33); pop = 1'b1;
        cyc();
        chk("swap_cnt", {28'd0, stack_count}, 1);
        push = 1'b0;
        exp_q.push_back(8'h44);
        cyc();
        pop = 1'b0;
        chk("swap_top_cnt", {28'd0, stack_count}, 0);
        push = 1'b1; pop = 1'b1; push_pc = 8'h44; exp_q.push_back(8'h44);
        cyc();
        push = 1'b0; pop = 1'b0;
        chk("swap_empty_cnt", {28'd0, stack_count}, 0);
        chk("swap_empty_popv", {31'd0, pop_valid}, 1);

        pop = 1'b1;
        cyc();
        pop = 1'b0;
        do_push(8'hA1);
        do_push(8'hA2);
        do_push(8'hA3);
        chk("pre_rst_cnt", {28'd0, stack_count}, 3);
        chk("pre_rst_err", {31'd0, stack_err}, 1);
        rs1 = 3'd3; rs2 = 3'd7;
        push = 1'b1; push_pc = 8'hA4;
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_cnt", {28'd0, stack_count}, 0);
        chk("mid_rst_pc", {24'd0, pop_pc}, 0);
        chk("mid_rst_err", {31'd0, stack_err}, 0);
        chk("mid_rst_rd1", rd1, 0);
        chk("mid_rst_rd2", rd2, 0);
        push = 1'b0;
        cyc();
        #3 reset = 1'b1;
        pop = 1'b1;
        cyc();
        pop = 1'b0;
        chk("post_rst_popv", {31'd0, pop_valid}, 0);
        chk("post_rst_empty", {31'd0, stack_empty}, 1);
        do_push(8'h5A);
        do_pop(8'h5A);
        cyc();
        cyc();

        n_tot++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL missing_pops: got %0d outstanding expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
